// File: rtl/weight_loader_pkg.sv
// Shared configuration for the weight loader: array geometry, FIFO depth and FSM encoding.
// Pulled into every weight_loader file with import weight_loader_pkg::*.
package weight_loader_pkg;

  localparam int sys_cols       = 4;
  localparam int W_BITWIDTH     = 8;
  localparam int w_buffer_depth = 2;

  localparam int WL_OCC_W  = $clog2(w_buffer_depth + 1);
  localparam int WL_COL_W  = (sys_cols > 1) ? $clog2(sys_cols) : 1;
  localparam int WL_NCOL_W = $clog2(sys_cols + 1);

  typedef enum logic [1:0] {
    WL_IDLE,
    WL_LOAD,
    WL_PAD,
    WL_DONE
  } wl_state_t;

endpackage

// File: rtl/weight_loader_occ_counter.sv
// Row occupancy of the weight FIFO bank: +1 per row started, -1 per row retired.
// Simultaneous inc/dec holds; a decrement at zero is ignored.
module wl_occ_counter #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_inc,
  input  logic                       i_dec,
  output logic [$clog2(DEPTH+1)-1:0] o_occ,
  output logic                       o_full
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] r_occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else if (i_inc && !i_dec) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (!i_inc && i_dec && (r_occ != '0)) begin
      r_occ <= r_occ - OCC_W'(1);
    end
  end

  assign o_occ  = r_occ;
  assign o_full = (r_occ == OCC_W'(DEPTH));

endmodule

// File: rtl/weight_loader.sv
// Steers a row-major weight stream into per-column FIFO write enables, throttled by FIFO row occupancy.
// Optional zero padding of short rows is enabled with the WLOAD_ZERO_PAD_EN macro.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int DEPTH = w_buffer_depth,
  parameter int ROW_W = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [ROW_W-1:0]                        num_rows,
  input  logic [WL_NCOL_W-1:0]                    num_cols,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  input  logic [W_BITWIDTH-1:0]                   s_data,
  input  logic                                    wb_last_valid,
  output logic [sys_cols-1:0]                     wr_en,
  output logic [sys_cols-1:0][W_BITWIDTH-1:0]     wr_data,
  output logic                                    busy,
  output logic                                    done,
  output logic [$clog2(DEPTH+1)-1:0]              occupancy,
  output wl_state_t                               dbg_state
);

  // Stream handshake: a beat transfers on a rising clk edge where s_valid & s_ready are both high;
  // s_ready depends only on registered state, never on s_valid.

  localparam logic [WL_COL_W-1:0] COLS_LAST = WL_COL_W'(sys_cols - 1);

  wl_state_t                              r_state, w_next_state;
  logic [WL_COL_W-1:0]                    r_col_cnt, w_col_next;
  logic [ROW_W-1:0]                       r_row_cnt, w_row_next;
  logic [ROW_W-1:0]                       r_num_rows;
  logic                                   r_fin, w_fin_next;
  logic [sys_cols-1:0]                    r_wr_en;
  logic [sys_cols-1:0][W_BITWIDTH-1:0]    r_wr_data;
  logic                                   w_wr_hit;
  logic [W_BITWIDTH-1:0]                  w_wr_val;
  logic [WL_COL_W-1:0]                    w_last_col;
  logic                                   w_accept, w_full, w_row_last, w_beats_last, w_pad_more;

`ifdef WLOAD_ZERO_PAD_EN
  logic [WL_COL_W-1:0] r_last_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_col <= COLS_LAST;
    end else if ((r_state == WL_IDLE) && start) begin
      if ((num_cols == '0) || (num_cols > WL_NCOL_W'(sys_cols))) begin
        r_last_col <= COLS_LAST;
      end else begin
        r_last_col <= WL_COL_W'(num_cols - WL_NCOL_W'(1));
      end
    end
  end

  assign w_last_col = r_last_col;
`else
  logic w_unused_cols;
  assign w_unused_cols = ^num_cols;
  assign w_last_col    = COLS_LAST;
`endif

  // A new row may only begin when the bank has a free row slot.
  assign s_ready      = (r_state == WL_LOAD) && !r_fin && !((r_col_cnt == '0) && w_full);
  assign w_accept     = s_valid && s_ready;
  assign w_row_last   = (r_row_cnt == (r_num_rows - ROW_W'(1)));
  assign w_beats_last = (r_col_cnt == w_last_col);
  assign w_pad_more   = (w_last_col != COLS_LAST);

  always_comb begin
    w_next_state = r_state;
    w_col_next   = r_col_cnt;
    w_row_next   = r_row_cnt;
    w_fin_next   = r_fin;
    w_wr_hit     = 1'b0;
    w_wr_val     = s_data;
    unique case (r_state)
      WL_IDLE: begin
        if (start) begin
          w_col_next   = '0;
          w_row_next   = '0;
          w_fin_next   = 1'b0;
          w_next_state = (num_rows != '0) ? WL_LOAD : WL_DONE;
        end
      end
      WL_LOAD: begin
        // r_fin marks the cycle the final write is on the bus; done follows it.
        if (r_fin) begin
          w_next_state = WL_DONE;
        end else if (w_accept) begin
          w_wr_hit = 1'b1;
          if (w_beats_last && w_pad_more) begin
            w_col_next   = r_col_cnt + WL_COL_W'(1);
            w_next_state = WL_PAD;
          end else if (w_beats_last) begin
            w_col_next = '0;
            w_row_next = r_row_cnt + ROW_W'(1);
            w_fin_next = w_row_last;
          end else begin
            w_col_next = r_col_cnt + WL_COL_W'(1);
          end
        end
      end
      WL_PAD: begin
        w_wr_hit = 1'b1;
        w_wr_val = '0;
        if (r_col_cnt == COLS_LAST) begin
          w_col_next   = '0;
          w_row_next   = r_row_cnt + ROW_W'(1);
          w_fin_next   = w_row_last;
          w_next_state = WL_LOAD;
        end else begin
          w_col_next = r_col_cnt + WL_COL_W'(1);
        end
      end
      WL_DONE: begin
        w_next_state = WL_IDLE;
      end
      default: begin
        w_next_state = WL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= WL_IDLE;
      r_col_cnt  <= '0;
      r_row_cnt  <= '0;
      r_num_rows <= '0;
      r_fin      <= 1'b0;
      r_wr_en    <= '0;
      r_wr_data  <= '0;
    end else begin
      r_state   <= w_next_state;
      r_col_cnt <= w_col_next;
      r_row_cnt <= w_row_next;
      r_fin     <= w_fin_next;
      r_wr_en   <= w_wr_hit ? (sys_cols'(1) << r_col_cnt) : '0;
      if ((r_state == WL_IDLE) && start) begin
        r_num_rows <= num_rows;
      end
      if (w_wr_hit) begin
        r_wr_data[r_col_cnt] <= w_wr_val;
      end
    end
  end

  wl_occ_counter #(
    .DEPTH(DEPTH)
  ) u_occ (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_accept && (r_col_cnt == '0)),
    .i_dec (wb_last_valid),
    .o_occ (occupancy),
    .o_full(w_full)
  );

  assign wr_en     = r_wr_en;
  assign wr_data   = r_wr_data;
  assign busy      = (r_state != WL_IDLE);
  assign done      = (r_state == WL_DONE);
  assign dbg_state = r_state;

endmodule
